xy_point_player: RTL and testbench
==================================

Name: xy_point_player

Overview:
- Parametrised successor to the vector-display front end.
- Stores up to DEPTH X/Y coordinate pairs, loaded over a valid/ready append port.
- Replays the stored pairs to the X/Y DAC outputs. The step rate comes from an internal programmable divider; the playback mode is loop, one-shot, ping-pong or hold.
- Sits between the UART/frame loader and the DAC pins.

Parameters:
- COORD_W, 8, width of each X and Y coordinate.
- DEPTH, 32, number of point slots (≥2). ADDR_W = $clog2(DEPTH); count is ADDR_W+1 bits wide.
- DIV_W, 6, width of the step-rate divider select.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  playback enable. When low, the index freezes and one-shot stop is cleared.
- div_sel  in  DIV_W  step period is div_sel+1 clk cycles.
- mode  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 hold.
- load_clear  in  1  pulse: empties the point buffer.
- wr_valid  in  1  append request.
- wr_x  in  COORD_W  X coordinate to append.
- wr_y  in  COORD_W  Y coordinate to append.
- wr_ready  out  1  append accepted this cycle if wr_valid is also high.
- xdac  out  COORD_W  X output.
- ydac  out  COORD_W  Y output.
- point_idx  out  ADDR_W  current playback index.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- blank  out  1  high when the buffer is empty (count==0).

Behaviour:
- Reset values: count=0, point_idx=0, dir=up, stopped=0, div_cnt=0, xdac=0, ydac=0, frame_done=0, blank=1. Memory contents are undefined after reset.
- Divider:
  - div_cnt increments every cycle.
  - When div_cnt >= div_sel: tick=1 and div_cnt←0.
  - The >= compare guarantees recovery when div_sel is lowered mid-count.
  - div_sel=0 gives a tick every cycle.
- Load port:
  - wr_ready = (count<DEPTH) && !load_clear.
  - On wr_valid && wr_ready: mem[count]←{wr_x,wr_y}, count←count+1.
  - When full (count==DEPTH), writes are dropped and wr_ready=0.
  - load_clear: count←0, point_idx←0, dir←up, stopped←0. It takes priority over a simultaneous write, which is dropped.
- Step condition: step = tick && enable && count>0 && !stopped && mode!=11. Let L = count-1.
- Loop (00):
  - idx<L → idx+1.
  - idx>=L → idx←0 and frame_done=1.
- One-shot (01):
  - idx<L → idx+1. If the new idx==L → frame_done=1 and stopped←1.
  - Index holds at L while stopped.
  - stopped is cleared by load_clear, by enable low, or by any change of mode.
- Ping-pong (10):
  - dir up: if idx<L → idx+1; else dir←down, idx←idx-1 (when L>0).
  - dir down: if idx>0 → idx-1; if the new idx==0 → dir←up and frame_done=1.
  - Endpoints are emitted once per pass; there are no repeats.
  - L==0: idx stays 0 and frame_done pulses on every step.
  - dir is forced to up whenever mode!=10.
- Hold (11): idx frozen and frame_done=0. The divider keeps running.
- Index clamp: if idx>L after count changes (possible only through load_clear), idx←0 on the next cycle.
- Output stage:
  - xdac/ydac are registered from mem[point_idx] every cycle: 1-cycle latency from a point_idx update.
  - When count==0, xdac=ydac=0.
  - A write to the slot currently being displayed is visible on the outputs 2 cycles after the write is accepted.
- frame_done is registered and is a single-cycle pulse, coincident with the point_idx update that causes it.
- blank is combinational from count.
- Reset mid-operation returns all state to the reset values immediately (asynchronous). The buffer is treated as empty.

Test Plan:
- Reset/idle: assert reset mid-playback → xdac=ydac=0, point_idx=0, blank=1, wr_ready=1, frame_done=0.
- Loop: load (10,20),(30,40),(50,60); div_sel=3, mode=00, enable=1 → X sequence 10,30,50,10…, each value held 4 cycles; frame_done pulses once per 12 cycles, on the 2→0 wrap.
- One-shot and restart: same 3 points, div_sel=0, mode=01 → idx 0,1,2 then holds at 2 with xdac=50; exactly 1 frame_done. Toggle enable low for 1 cycle → playback resumes advancing from idx 2 (wraps to 0, then stops again at 2).
- Ping-pong: load 4 points with X=1,2,3,4; div_sel=0, mode=10 → X sequence 1,2,3,4,3,2,1,2…; frame_done pulses on each return to idx 0 (every 6 steps).
- Full/clear collision: write 32 points → count=32, wr_ready=0, 33rd write dropped. Assert load_clear together with wr_valid → count=0, blank=1, write dropped, idx=0.
- Divider change: div_cnt at 5 with div_sel=6, then set div_sel=2 → tick on the next cycle, then every 3 cycles. Set mode=11 → idx frozen and no frame_done.

Source files
------------

// File: rtl/xy_point_player_if.sv
// Append/clear port of the XY point player: the frame loader pushes coordinate
// pairs; wr_valid/wr_ready follow valid/ready: a pair moves on a rising clk edge where both are high.
interface xy_point_player_if #(
    parameter int COORD_W = 8
);
    logic               load_clear;
    logic               wr_valid;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               wr_ready;

    modport master (
        output load_clear,
        output wr_valid,
        output wr_x,
        output wr_y,
        input  wr_ready
    );

    modport slave (
        input  load_clear,
        input  wr_valid,
        input  wr_x,
        input  wr_y,
        output wr_ready
    );
endinterface

// File: rtl/xy_point_player.sv
// Point buffer plus replay engine for an XY vector display: stores up to DEPTH
// coordinate pairs and steps through them at a programmable rate in loop/one-shot/ping-pong/hold.
module xy_point_player #(
    parameter  int COORD_W = 8,
    parameter  int DEPTH   = 32,
    parameter  int DIV_W   = 6,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIV_W-1:0]    div_sel,
    input  logic [1:0]          mode,
    xy_point_player_if.slave    ld,
    output logic [COORD_W-1:0]  xdac,
    output logic [COORD_W-1:0]  ydac,
    output logic [ADDR_W-1:0]   point_idx,
    output logic                frame_done,
    output logic                blank,
    output logic [1:0]          state_dbg
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [1:0] MODE_LOOP    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    // ST_DOWN is the ping-pong return leg, ST_STOPPED the parked end of a one-shot.
    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DOWN    = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         count;
    logic [DIV_W-1:0]         div_cnt;
    logic [1:0]               mode_q;
    logic [2*COORD_W-1:0]     mem [DEPTH];
    logic [2*COORD_W-1:0]     out_q;
    logic                     tick;
    logic                     step;
    logic                     wr_fire;
    logic                     mode_chg;
    logic [CNT_W-1:0]         last;
    logic [CNT_W-1:0]         idx_ext;
    logic [ADDR_W-1:0]        idx_nxt;
    logic                     fd_nxt;

    assign tick       = (div_cnt >= div_sel);
    assign last       = count - CNT_W'(1);
    assign idx_ext    = {1'b0, point_idx};
    assign mode_chg   = (mode != mode_q);
    assign blank      = (count == '0);
    assign ld.wr_ready = (count < CNT_W'(DEPTH)) && !ld.load_clear;
    assign wr_fire    = ld.wr_valid && ld.wr_ready;
    assign step       = tick && enable && !blank && (state != ST_STOPPED) && (mode != MODE_HOLD);
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_UP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_UP: begin
                if (step && mode == MODE_ONESHOT && idx_ext < last &&
                    idx_ext + CNT_W'(1) == last) begin
                    state_nxt = ST_STOPPED;
                end else if (step && mode == MODE_PINGPONG && idx_ext >= last &&
                             last > CNT_W'(1)) begin
                    // With only two points the turn lands on slot 0, so the leg stays up.
                    state_nxt = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (mode != MODE_PINGPONG) begin
                    state_nxt = ST_UP;
                end else if (step && point_idx <= ADDR_W'(1)) begin
                    state_nxt = ST_UP;
                end
            end
            ST_STOPPED: begin
                if (!enable || mode_chg) begin
                    state_nxt = ST_UP;
                end
            end
            default: state_nxt = ST_UP;
        endcase
        if (ld.load_clear) begin
            state_nxt = ST_UP;
        end
    end

    always_comb begin
        idx_nxt = point_idx;
        fd_nxt  = 1'b0;
        if (ld.load_clear) begin
            idx_nxt = '0;
        end else if (step) begin
            case (mode)
                MODE_LOOP: begin
                    if (idx_ext < last) begin
                        idx_nxt = point_idx + ADDR_W'(1);
                    end else begin
                        idx_nxt = '0;
                        fd_nxt  = 1'b1;
                    end
                end
                MODE_ONESHOT: begin
                    if (idx_ext < last) begin
                        idx_nxt = point_idx + ADDR_W'(1);
                        fd_nxt  = (idx_ext + CNT_W'(1) == last);
                    end else begin
                        idx_nxt = '0;
                    end
                end
                MODE_PINGPONG: begin
                    if (state == ST_DOWN) begin
                        if (point_idx != '0) begin
                            idx_nxt = point_idx - ADDR_W'(1);
                            fd_nxt  = (point_idx == ADDR_W'(1));
                        end
                    end else if (idx_ext < last) begin
                        idx_nxt = point_idx + ADDR_W'(1);
                    end else if (last != '0) begin
                        idx_nxt = point_idx - ADDR_W'(1);
                        fd_nxt  = (last == CNT_W'(1));
                    end else begin
                        fd_nxt = 1'b1;
                    end
                end
                default: idx_nxt = point_idx;
            endcase
        end else if (!blank && idx_ext > last) begin
            idx_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            point_idx  <= '0;
            div_cnt    <= '0;
            mode_q     <= '0;
            frame_done <= 1'b0;
            out_q      <= '0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
            mode_q     <= mode;
            point_idx  <= idx_nxt;
            frame_done <= fd_nxt;
            out_q      <= blank ? '0 : mem[point_idx];
            if (ld.load_clear) begin
                count <= '0;
            end else if (wr_fire) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Storage has no reset; the count alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[count[ADDR_W-1:0]] <= {ld.wr_x, ld.wr_y};
        end
    end

    assign xdac = blank ? '0 : out_q[2*COORD_W-1:COORD_W];
    assign ydac = blank ? '0 : out_q[COORD_W-1:0];
endmodule

// File: tb/tb_xy_point_player.sv
// Bench for xy_point_player: directed scenarios then random traffic, every cycle
// checked against a queue-based model of the point buffer and replay rules.
module tb_xy_point_player;
    localparam int COORD_W = 8;
    localparam int DEPTH   = 32;
    localparam int DIV_W   = 6;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int EXP_W   = 2*COORD_W + ADDR_W + 3;

    bit clk = 1'b1;
    always #5 clk = ~clk;

    logic               r_reset;
    logic               r_enable;
    logic [DIV_W-1:0]   r_div_sel;
    logic [1:0]         r_mode;
    logic               r_load_clear;
    logic               r_wr_valid;
    logic [COORD_W-1:0] r_wr_x;
    logic [COORD_W-1:0] r_wr_y;

    logic [COORD_W-1:0] xdac;
    logic [COORD_W-1:0] ydac;
    logic [ADDR_W-1:0]  point_idx;
    logic               frame_done;
    logic               blank;
    logic [1:0]         state_dbg;

    xy_point_player_if #(.COORD_W(COORD_W)) ld_if ();
    assign ld_if.load_clear = r_load_clear;
    assign ld_if.wr_valid   = r_wr_valid;
    assign ld_if.wr_x       = r_wr_x;
    assign ld_if.wr_y       = r_wr_y;

    xy_point_player #(.COORD_W(COORD_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (r_reset),
        .enable     (r_enable),
        .div_sel    (r_div_sel),
        .mode       (r_mode),
        .ld         (ld_if.slave),
        .xdac       (xdac),
        .ydac       (ydac),
        .point_idx  (point_idx),
        .frame_done (frame_done),
        .blank      (blank),
        .state_dbg  (state_dbg)
    );

    // Reference model: the buffer is a queue, playback is plain integer arithmetic.
    logic [2*COORD_W-1:0] m_pts[$];
    int                   m_idx;
    bit                   m_dir_up;
    bit                   m_stopped;
    int                   m_div;
    bit                   m_fd;
    logic [2*COORD_W-1:0] m_out;
    logic [1:0]           m_prev_mode;

    logic [EXP_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_pts.delete();
        m_idx       = 0;
        m_dir_up    = 1'b1;
        m_stopped   = 1'b0;
        m_div       = 0;
        m_fd        = 1'b0;
        m_out       = '0;
        m_prev_mode = 2'b00;
    endtask

    task automatic model_clock();
        int sz;
        int last;
        bit tick;
        bit step;
        logic [2*COORD_W-1:0] nxt_out;
        if (r_reset) begin
            model_reset();
            return;
        end
        sz      = m_pts.size();
        last    = sz - 1;
        tick    = (m_div >= int'(r_div_sel));
        m_div   = tick ? 0 : m_div + 1;
        nxt_out = (sz == 0) ? '0 : m_pts[m_idx];
        step    = tick && r_enable && sz > 0 && !m_stopped && r_mode != 2'b11;
        m_fd    = 1'b0;
        if (r_load_clear) begin
            m_pts.delete();
            m_idx     = 0;
            m_dir_up  = 1'b1;
            m_stopped = 1'b0;
        end else begin
            if (!r_enable || r_mode != m_prev_mode) m_stopped = 1'b0;
            if (r_mode != 2'b10) m_dir_up = 1'b1;
            if (step) begin
                case (r_mode)
                    2'b00: begin
                        if (m_idx < last) m_idx++;
                        else begin m_idx = 0; m_fd = 1'b1; end
                    end
                    2'b01: begin
                        if (m_idx < last) begin
                            m_idx++;
                            if (m_idx == last) begin m_fd = 1'b1; m_stopped = 1'b1; end
                        end else m_idx = 0;
                    end
                    2'b10: begin
                        if (!m_dir_up) begin
                            if (m_idx > 0) begin
                                m_idx--;
                                if (m_idx == 0) begin m_dir_up = 1'b1; m_fd = 1'b1; end
                            end else m_dir_up = 1'b1;
                        end else if (m_idx < last) m_idx++;
                        else if (last > 0) begin
                            m_idx--;
                            if (m_idx == 0) m_fd = 1'b1;
                            else m_dir_up = 1'b0;
                        end else m_fd = 1'b1;
                    end
                    default: ;
                endcase
            end else if (sz > 0 && m_idx > last) m_idx = 0;
            if (r_wr_valid && sz < DEPTH) m_pts.push_back({r_wr_x, r_wr_y});
        end
        m_prev_mode = r_mode;
        m_out       = nxt_out;
    endtask

    // One clock: publish what the outputs must show this cycle, then advance the model on the edge.
    task automatic cyc();
        int sz;
        logic [EXP_W-1:0] e;
        if (r_reset) model_reset();
        sz = m_pts.size();
        e[EXP_W-1 -: COORD_W]           = (sz == 0) ? '0 : m_out[2*COORD_W-1:COORD_W];
        e[EXP_W-1-COORD_W -: COORD_W]   = (sz == 0) ? '0 : m_out[COORD_W-1:0];
        e[ADDR_W+2:3]                   = ADDR_W'(m_idx);
        e[2]                            = m_fd;
        e[1]                            = (sz == 0);
        e[0]                            = (sz < DEPTH) && !r_load_clear;
        exp_q.push_back(e);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic write_pt(logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
        r_wr_valid = 1'b1;
        r_wr_x     = x;
        r_wr_y     = y;
        cyc();
        r_wr_valid = 1'b0;
    endtask

    task automatic clear_buf();
        r_load_clear = 1'b1;
        cyc();
        r_load_clear = 1'b0;
    endtask

    initial begin : monitor
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("xdac",       int'(xdac),       int'(e[EXP_W-1 -: COORD_W]));
                check("ydac",       int'(ydac),       int'(e[EXP_W-1-COORD_W -: COORD_W]));
                check("point_idx",  int'(point_idx),  int'(e[ADDR_W+2:3]));
                check("frame_done", int'(frame_done), int'(e[2]));
                check("blank",      int'(blank),      int'(e[1]));
                check("wr_ready",   int'(ld_if.wr_ready), int'(e[0]));
            end
        end
    end

    initial begin : stimulus
        r_reset      = 1'b1;
        r_enable     = 1'b0;
        r_div_sel    = '0;
        r_mode       = 2'b00;
        r_load_clear = 1'b0;
        r_wr_valid   = 1'b0;
        r_wr_x       = '0;
        r_wr_y       = '0;
        model_reset();
        run(3);
        r_reset = 1'b0;
        run(2);

        // Loop: three points, step every 4 cycles.
        write_pt(8'd10, 8'd20);
        write_pt(8'd30, 8'd40);
        write_pt(8'd50, 8'd60);
        r_div_sel = 6'd3;
        r_mode    = 2'b00;
        r_enable  = 1'b1;
        run(40);

        // Reset in the middle of playback.
        r_reset = 1'b1;
        cyc();
        r_reset = 1'b0;
        run(2);

        // One-shot, then a one-cycle enable drop restarts it.
        r_enable = 1'b0;
        write_pt(8'd10, 8'd20);
        write_pt(8'd30, 8'd40);
        write_pt(8'd50, 8'd60);
        r_div_sel = 6'd0;
        r_mode    = 2'b01;
        r_enable  = 1'b1;
        run(10);
        r_enable = 1'b0;
        cyc();
        r_enable = 1'b1;
        run(10);

        // Ping-pong over four points.
        r_enable = 1'b0;
        clear_buf();
        for (int i = 1; i <= 4; i++) write_pt(COORD_W'(i), COORD_W'(10 * i));
        r_mode   = 2'b10;
        r_enable = 1'b1;
        run(30);

        // Fill to DEPTH, one dropped write, then clear colliding with a write.
        clear_buf();
        for (int i = 0; i < DEPTH + 1; i++) write_pt(COORD_W'($urandom_range(0, 255)), COORD_W'(i));
        run(3);
        r_load_clear = 1'b1;
        r_wr_valid   = 1'b1;
        cyc();
        r_load_clear = 1'b0;
        r_wr_valid   = 1'b0;
        run(2);

        // Lowering div_sel mid-count, then hold mode.
        write_pt(8'd1, 8'd2);
        write_pt(8'd3, 8'd4);
        write_pt(8'd5, 8'd6);
        r_mode    = 2'b00;
        r_div_sel = 6'd6;
        run(6);
        r_div_sel = 6'd2;
        run(12);
        r_mode = 2'b11;
        run(12);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            r_reset      = ($urandom_range(0, 799) == 0);
            r_load_clear = ($urandom_range(0, 149) == 0);
            r_wr_valid   = ($urandom_range(0, 2) == 0);
            r_wr_x       = COORD_W'($urandom_range(0, 255));
            r_wr_y       = COORD_W'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) r_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) r_div_sel = DIV_W'($urandom_range(0, 4));
            r_enable = ($urandom_range(0, 9) != 0);
            cyc();
        end
        r_reset      = 1'b0;
        r_load_clear = 1'b0;
        r_wr_valid   = 1'b0;
        run(3);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
